// File: rtl/weight_seq_pkg.sv
`default_nettype none
// =============================================================================
// weight_seq_pkg : FSM state encoding and output-FIFO sizing for weight_seq_ctrl
// Rev 1.0
// =============================================================================
package weight_seq_pkg;

   localparam int c_FIFO_DEPTH = 4;
   localparam int c_FIFO_CNT_W = $clog2(c_FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/weight_seq_ctrl_if.sv
`default_nettype none
// =============================================================================
// weight_seq_ctrl_if : host load stream and compute read-out stream
// Rev 1.0
// =============================================================================
interface weight_seq_ctrl_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  ld_valid;
   logic                  ld_ready;
   logic [DATA_WIDTH-1:0] ld_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_last;

   // master = host/compute side, slave = the sequencer
   modport master (
      output ld_valid, ld_data, rd_ready,
      input  ld_ready, rd_valid, rd_data, rd_last
   );
   modport slave (
      input  ld_valid, ld_data, rd_ready,
      output ld_ready, rd_valid, rd_data, rd_last
   );
endinterface
`default_nettype wire

// File: rtl/weight_seq_fifo.sv
`default_nettype none
// =============================================================================
// weight_seq_fifo : 4-entry valid/ready output FIFO with synchronous flush
// Rev 1.0
// =============================================================================
module weight_seq_fifo
   import weight_seq_pkg::*;
#(
   parameter int WIDTH = 17
)(
   input  wire logic                    clk,
   input  wire logic                    i_flush,
   input  wire logic                    i_push,
   input  wire logic [WIDTH-1:0]        i_data,
   input  wire logic                    i_pop,
   output logic                         o_valid,
   output logic [WIDTH-1:0]             o_data,
   output logic [c_FIFO_CNT_W-1:0]      o_count
);
   localparam int c_PW = $clog2(c_FIFO_DEPTH);

   logic [WIDTH-1:0]        r_mem [c_FIFO_DEPTH];
   logic [c_PW-1:0]         r_wptr;
   logic [c_PW-1:0]         r_rptr;
   logic [c_FIFO_CNT_W-1:0] r_count;
   logic                    w_push;
   logic                    w_pop;

   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && (r_count != c_FIFO_CNT_W'(c_FIFO_DEPTH));

   always_ff @(posedge clk) begin
      if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + c_PW'(1);
         if (w_pop)  r_rptr <= r_rptr + c_PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_FIFO_CNT_W'(1);
            2'b01:   r_count <= r_count - c_FIFO_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   assign o_valid = (r_count != '0);
   assign o_data  = o_valid ? r_mem[r_rptr] : '0;
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/weight_seq_ctrl.sv
`default_nettype none
// =============================================================================
// weight_seq_ctrl : loads weights into external memory and streams them out.
// Optional load checksum enabled by macro WEIGHT_SEQ_CHECKSUM_EN. Rev 1.0
// =============================================================================
module weight_seq_ctrl
   import weight_seq_pkg::*;
#(
   parameter  int N_WEIGHT   = 256,
   parameter  int DATA_WIDTH = 16,
   localparam int AW         = $clog2(N_WEIGHT)
)(
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic                  load_start,
   input  wire logic                  run_start,
   weight_seq_ctrl_if.slave           bus,
   output logic                       busy,
   output logic                       done,
   output logic [DATA_WIDTH-1:0]      checksum,
   output logic                       mem_wen,
   output logic                       mem_ren,
   output logic [AW-1:0]              mem_wadd,
   output logic [AW-1:0]              mem_radd,
   output logic [DATA_WIDTH-1:0]      mem_win,
   input  wire logic [DATA_WIDTH-1:0] mem_wout
);
   localparam logic [AW-1:0] c_LAST_ADDR = AW'(N_WEIGHT - 1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [AW-1:0]           r_waddr;
   logic [AW-1:0]           r_raddr;
   logic                    r_issue_done;
   logic                    r_inflight;
   logic                    r_inflight_last;
   logic                    r_done;
   logic                    w_ld_fire;
   logic                    w_rd_fire;
   logic                    w_ren;
   logic                    w_credit_ok;
   logic                    w_done_set;
   logic                    w_fifo_valid;
   logic [DATA_WIDTH:0]     w_fifo_head;
   logic [c_FIFO_CNT_W-1:0] w_fifo_count;
   logic [DATA_WIDTH-1:0]   w_checksum;

   assign w_ld_fire   = rst_n && (r_state == S_LOAD) && bus.ld_valid;
   assign w_rd_fire   = rst_n && w_fifo_valid && bus.rd_ready;
   assign w_credit_ok = (int'(w_fifo_count) + int'(r_inflight)) < c_FIFO_DEPTH;

   // The first read is launched from IDLE so data reaches the FIFO head two cycles after run_start.
   always_comb begin
      w_state_nxt = r_state;
      w_ren       = 1'b0;
      w_done_set  = 1'b0;
      if (rst_n) begin
         case (r_state)
            S_IDLE: begin
               if (load_start) begin
                  w_state_nxt = S_LOAD;
               end else if (run_start) begin
                  w_state_nxt = S_RUN;
                  w_ren       = 1'b1;
               end
            end
            S_LOAD: begin
               if (w_ld_fire && (r_waddr == c_LAST_ADDR)) begin
                  w_state_nxt = S_IDLE;
                  w_done_set  = 1'b1;
               end
            end
            S_RUN: begin
               w_ren = !r_issue_done && w_credit_ok;
               if (w_rd_fire && w_fifo_head[DATA_WIDTH]) begin
                  w_state_nxt = S_IDLE;
                  w_done_set  = 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_done          <= 1'b0;
         r_waddr         <= '0;
         r_raddr         <= '0;
         r_issue_done    <= 1'b0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_done          <= w_done_set;
         r_inflight      <= w_ren;
         r_inflight_last <= w_ren && (r_raddr == c_LAST_ADDR);
         if (w_ld_fire) begin
            r_waddr <= (r_waddr == c_LAST_ADDR) ? '0 : r_waddr + AW'(1);
         end
         if ((r_state == S_RUN) && w_done_set) begin
            r_raddr      <= '0;
            r_issue_done <= 1'b0;
         end else if (w_ren) begin
            if (r_raddr == c_LAST_ADDR) r_issue_done <= 1'b1;
            else                        r_raddr      <= r_raddr + AW'(1);
         end
      end
   end

`ifdef WEIGHT_SEQ_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] r_checksum;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_checksum <= '0;
      end else if ((r_state == S_IDLE) && (w_state_nxt == S_LOAD)) begin
         r_checksum <= '0;
      end else if (w_ld_fire) begin
         r_checksum <= r_checksum ^ bus.ld_data;
      end
   end

   assign w_checksum = r_checksum;
`else
   assign w_checksum = '0;
`endif

   weight_seq_fifo #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_fifo (
      .clk     (clk),
      .i_flush (!rst_n),
      .i_push  (r_inflight),
      .i_data  ({r_inflight_last, mem_wout}),
      .i_pop   (w_rd_fire),
      .o_valid (w_fifo_valid),
      .o_data  (w_fifo_head),
      .o_count (w_fifo_count)
   );

   // Every output is forced low while reset is held, even before the first reset edge.
   assign busy         = rst_n && (r_state != S_IDLE);
   assign done         = rst_n && r_done;
   assign checksum     = rst_n ? w_checksum : '0;
   assign bus.ld_ready = rst_n && (r_state == S_LOAD);
   assign bus.rd_valid = rst_n && w_fifo_valid;
   assign bus.rd_data  = rst_n ? w_fifo_head[DATA_WIDTH-1:0] : '0;
   assign bus.rd_last  = rst_n && w_fifo_valid && w_fifo_head[DATA_WIDTH];
   assign mem_wen      = w_ld_fire;
   assign mem_win      = w_ld_fire ? bus.ld_data : '0;
   assign mem_wadd     = rst_n ? r_waddr : '0;
   assign mem_ren      = w_ren;
   assign mem_radd     = rst_n ? r_raddr : '0;

endmodule
`default_nettype wire

// File: tb/tb_weight_seq_ctrl.sv
`default_nettype none
// =============================================================================
// tb_weight_seq_ctrl : directed self-checking bench, N_WEIGHT=8 and N_WEIGHT=5
// Rev 1.0
// =============================================================================
`timescale 1ns/1ps
module tb_weight_seq_ctrl;
   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, load_start, run_start;
   logic          busy, done, mem_wen, mem_ren;
   logic [DW-1:0] checksum, mem_win, mem_wout;
   logic [2:0]    mem_wadd, mem_radd;

   logic          load5, run5, busy5, done5, wen5, ren5;
   logic [DW-1:0] cs5, win5, wout5;
   logic [2:0]    wadd5, radd5;

   weight_seq_ctrl_if #(.DATA_WIDTH(DW)) bus  ();
   weight_seq_ctrl_if #(.DATA_WIDTH(DW)) bus5 ();

   weight_seq_ctrl #(.N_WEIGHT(8), .DATA_WIDTH(DW)) u_dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .run_start(run_start),
      .bus(bus), .busy(busy), .done(done), .checksum(checksum),
      .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wadd(mem_wadd), .mem_radd(mem_radd),
      .mem_win(mem_win), .mem_wout(mem_wout)
   );

   weight_seq_ctrl #(.N_WEIGHT(5), .DATA_WIDTH(DW)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .load_start(load5), .run_start(run5),
      .bus(bus5), .busy(busy5), .done(done5), .checksum(cs5),
      .mem_wen(wen5), .mem_ren(ren5), .mem_wadd(wadd5), .mem_radd(radd5),
      .mem_win(win5), .mem_wout(wout5)
   );

   // External weight memories; the 5-word one is preloaded with 0x10..0x14 under reset.
   logic [DW-1:0] mem8 [8];
   logic [DW-1:0] mem5 [8];
   always @(posedge clk) begin
      if (mem_wen) mem8[mem_wadd] <= mem_win;
      if (mem_ren) mem_wout <= mem8[mem_radd];
      if (!rst_n) for (int i = 0; i < 8; i++) mem5[i] <= DW'(16'h0010 + i);
      else if (wen5) mem5[wadd5] <= win5;
      if (ren5) wout5 <= mem5[radd5];
   end

   logic          clr_mon;
   int            wr_cnt, ren_cnt, done_cnt, issued, taken, max_out, stall_err, last_cnt;
   logic [2:0]    wadd_log [8];
   logic [DW-1:0] got_q [$];
   logic [DW-1:0] last_word, prev_data;
   logic          prev_stall;
   int            ren5_cnt, max_radd5, got5_cnt, last5_cnt, sum5;
   logic [DW-1:0] last5;

   always @(negedge clk) begin
      if (clr_mon) begin
         wr_cnt = 0; ren_cnt = 0; done_cnt = 0; issued = 0; taken = 0; max_out = 0;
         stall_err = 0; last_cnt = 0; got_q.delete(); last_word = '0; prev_stall = 1'b0;
         prev_data = '0; ren5_cnt = 0; max_radd5 = 0; got5_cnt = 0; last5_cnt = 0;
         sum5 = 0; last5 = '0;
      end else begin
         if (mem_wen) begin
            if (wr_cnt < 8) wadd_log[wr_cnt] = mem_wadd;
            wr_cnt++;
         end
         if (mem_ren) begin ren_cnt++; issued++; end
         if (issued - taken > max_out) max_out = issued - taken;
         if (done) done_cnt++;
         if (prev_stall && (!bus.rd_valid || bus.rd_data != prev_data)) stall_err++;
         prev_stall = bus.rd_valid && !bus.rd_ready;
         prev_data  = bus.rd_data;
         if (bus.rd_valid && bus.rd_ready) begin
            got_q.push_back(bus.rd_data);
            taken++;
            if (bus.rd_last) begin last_cnt++; last_word = bus.rd_data; end
         end
         if (ren5) begin
            ren5_cnt++;
            if (int'(radd5) > max_radd5) max_radd5 = int'(radd5);
         end
         if (bus5.rd_valid && bus5.rd_ready) begin
            got5_cnt++;
            sum5 += int'(bus5.rd_data);
            if (bus5.rd_last) begin last5_cnt++; last5 = bus5.rd_data; end
         end
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      clr_mon = 1'b1;
      @(negedge clk);
      #1;
      clr_mon = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_ctl"}, 32'({busy, done, bus.ld_ready, bus.rd_valid, bus.rd_last, mem_wen, mem_ren}), 32'd0);
      check_eq({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
      check_eq({tag, "_addr"}, 32'({mem_wadd, mem_radd}), 32'd0);
      check_eq({tag, "_win"}, 32'(mem_win), 32'd0);
      check_eq({tag, "_checksum"}, 32'(checksum), 32'd0);
   endtask

   // Full read-out with rd_ready high: words 1..8 back-to-back from the second cycle after run_start.
   task automatic run_full(input string tag);
      bus.rd_ready = 1'b1;
      run_start    = 1'b1;
      step();
      run_start = 1'b0;
      #1;
      check_eq({tag, "_no_early_valid"}, 32'(bus.rd_valid), 32'd0);
      step(); #1;
      for (int k = 0; k < 8; k++) begin
         check_eq({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
         check_eq({tag, "_data"}, 32'(bus.rd_data), 32'(k + 1));
         check_eq({tag, "_last"}, 32'(bus.rd_last), 32'(k == 7));
         step(); #1;
      end
      check_eq({tag, "_done"}, 32'(done), 32'd1);
      check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
      step(); #1;
      check_eq({tag, "_done_single"}, 32'(done), 32'd0);
   endtask

   logic [DW-1:0] exp_cs;
   int            cyc;

   initial begin
      rst_n = 1'b0; load_start = 1'b0; run_start = 1'b0; clr_mon = 1'b1;
      bus.ld_valid = 1'b0; bus.ld_data = '0; bus.rd_ready = 1'b0;
      load5 = 1'b0; run5 = 1'b0; bus5.ld_valid = 1'b0; bus5.ld_data = '0; bus5.rd_ready = 1'b0;
      repeat (2) step();
      #1;
      check_outputs_zero("reset");

      rst_n = 1'b1;
      step();
      clear_mon();

      // Simultaneous start requests: LOAD wins, no read issued
      step();
      load_start = 1'b1; run_start = 1'b1;
      #1;
      check_eq("both_start_no_ren", 32'(mem_ren), 32'd0);
      step();
      load_start = 1'b0; run_start = 1'b0;
      #1;
      check_eq("load_busy", 32'(busy), 32'd1);
      check_eq("load_ready", 32'(bus.ld_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 1) begin
            bus.ld_valid = 1'b0;
            run_start    = 1'b1;
            step();
            run_start = 1'b0;
         end
         bus.ld_valid = 1'b1;
         bus.ld_data  = DW'(i + 1);
         step();
      end
      bus.ld_valid = 1'b0;
      #1;
      check_eq("load_done", 32'(done), 32'd1);
      check_eq("load_busy_low", 32'(busy), 32'd0);
      check_eq("load_ready_low", 32'(bus.ld_ready), 32'd0);
      step(); #1;
      check_eq("load_done_single", 32'(done), 32'd0);
      check_eq("load_busy_idle", 32'(busy), 32'd0);
      check_eq("load_done_count", 32'(done_cnt), 32'd1);
      check_eq("load_write_count", 32'(wr_cnt), 32'd8);
      for (int i = 0; i < 8; i++) check_eq("load_wadd_order", 32'(wadd_log[i]), 32'(i));
      check_eq("load_no_ren", 32'(ren_cnt), 32'd0);
`ifdef WEIGHT_SEQ_CHECKSUM_EN
      exp_cs = 16'h0008;
`else
      exp_cs = 16'h0000;
`endif
      check_eq("load_checksum", 32'(checksum), 32'(exp_cs));

      step();
      run_full("run1");

      // rd_ready pattern 1,0,0,1 repeating
      clear_mon();
      step();
      run_start = 1'b1;
      cyc = 0;
      while (!done && cyc < 100) begin
         bus.rd_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         step();
         run_start = 1'b0;
         cyc++;
      end
      check_eq("toggle_done_seen", 32'(done), 32'd1);
      check_eq("toggle_word_count", 32'(got_q.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         check_eq("toggle_data", 32'((i < got_q.size()) ? got_q[i] : 16'hDEAD), 32'(i + 1));
      check_eq("toggle_last_count", 32'(last_cnt), 32'd1);
      check_eq("toggle_last_word", 32'(last_word), 32'h0008);
      check_eq("toggle_stable", 32'(stall_err), 32'd0);
      check_eq("toggle_outstanding_le4", 32'(max_out <= 4), 32'd1);
      check_eq("toggle_read_count", 32'(ren_cnt), 32'd8);
      step(); step();

      // Reset after three words of a run
      bus.rd_ready = 1'b1;
      run_start    = 1'b1;
      step();
      run_start = 1'b0;
      repeat (4) step();
      rst_n = 1'b0;
      step(); #1;
      check_outputs_zero("midrun_reset");
      rst_n = 1'b1;
      step(); #1;
      check_eq("midrun_no_done", 32'(done), 32'd0);
      run_full("rerun");

      // Non-power-of-two depth
      clear_mon();
      step();
      bus5.rd_ready = 1'b1;
      run5 = 1'b1;
      step();
      run5 = 1'b0;
      cyc = 0;
      while (!done5 && cyc < 60) begin
         step();
         cyc++;
      end
      check_eq("n5_done_seen", 32'(done5), 32'd1);
      step();
      check_eq("n5_read_count", 32'(ren5_cnt), 32'd5);
      check_eq("n5_max_radd", 32'(max_radd5), 32'd4);
      check_eq("n5_word_count", 32'(got5_cnt), 32'd5);
      check_eq("n5_data_sum", 32'(sum5), 32'h005A);
      check_eq("n5_last_word", 32'(last5), 32'h0014);
      check_eq("n5_last_count", 32'(last5_cnt), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
